vde_nx1_fifo: RTL and testbench

//  Parametrised N-lane-in / 1-lane-out serialising FIFO for the VDE pixel path.

---
 rtl/vde_nx1_fifo_if.sv | 39 +++
 rtl/vde_nx1_fifo.sv | 98 +++++++++
 tb/tb_vde_nx1_fifo.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vde_nx1_fifo_if.sv
// Handshake bundle between a wide VDE producer, the N-to-1 FIFO and the per-pixel consumer.
// slave is the FIFO side; master is the producer/consumer side.
interface vde_nx1_fifo_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LANES = 4
) ();
   localparam int unsigned LW = $clog2(LANES + 1);

   logic                   data_in_ready_o;
   logic                   data_in_valid_i;
   logic [LANES*WIDTH-1:0] data_in_i;
   logic [LW-1:0]          data_in_cnt_i;
   logic                   data_out_ready_i;
   logic                   data_out_valid_o;
   logic [WIDTH-1:0]       data_out_data_o;
   logic                   data_out_last_o;

   modport slave (
      output data_in_ready_o,
      input  data_in_valid_i,
      input  data_in_i,
      input  data_in_cnt_i,
      input  data_out_ready_i,
      output data_out_valid_o,
      output data_out_data_o,
      output data_out_last_o
   );

   modport master (
      input  data_in_ready_o,
      output data_in_valid_i,
      output data_in_i,
      output data_in_cnt_i,
      output data_out_ready_i,
      input  data_out_valid_o,
      input  data_out_data_o,
      input  data_out_last_o
   );
endinterface

// File: rtl/vde_nx1_fifo.sv
// N-lane-in / 1-lane-out serialising FIFO; drains one lane per handshake, lane 0 first.
// Optional level_o / lanes_left_o outputs when VDE_NX1_FIFO_LEVEL_EN is defined.
module vde_nx1_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LANES = 4,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned LW   = $clog2(LANES + 1),
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush_i,
   vde_nx1_fifo_if.slave bus
`ifdef VDE_NX1_FIFO_LEVEL_EN
   ,
   output logic [AW:0]   level_o,
   output logic [LW-1:0] lanes_left_o
`endif
);

   logic [LANES*WIDTH-1:0] mem_q [DEPTH];
   logic [LW-1:0]          cnt_mem_q [DEPTH];

   logic [AW:0]            wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]          rd_lane_q;
   logic [AW-1:0]          wr_idx, rd_idx;
   logic                   empty, full, push, pop, last;
   logic [LANES*WIDTH-1:0] head;
   logic [LW-1:0]          head_cnt, cnt_wr;
   logic [WIDTH-1:0]       lane_data;

   assign wr_idx = wr_ptr_q[AW-1:0];
   assign rd_idx = rd_ptr_q[AW-1:0];
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

   assign head     = mem_q[rd_idx];
   assign head_cnt = cnt_mem_q[rd_idx];
   assign last     = !empty && (rd_lane_q == head_cnt - LW'(1));

   // A flush or reset wins over any handshake in the same cycle.
   assign push = bus.data_in_valid_i && !full && !flush_i && !rst_i;
   assign pop  = bus.data_out_ready_i && !empty && !flush_i && !rst_i;

   // Illegal counts (0 or above LANES) are stored as a full entry.
   assign cnt_wr = (bus.data_in_cnt_i == '0 || bus.data_in_cnt_i > LW'(LANES)) ?
                   LW'(LANES) : bus.data_in_cnt_i;

   always_comb begin
      lane_data = '0;
      for (int k = 0; k < int'(LANES); k++) begin
         if (rd_lane_q == LW'(k)) lane_data = head[k*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rd_lane_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop) begin
            if (last) begin
               rd_lane_q <= '0;
               rd_ptr_q  <= rd_ptr_q + (AW+1)'(1);
            end else begin
               rd_lane_q <= rd_lane_q + LW'(1);
            end
         end
      end
   end

   // Storage is not reset; only the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_idx]     <= bus.data_in_i;
         cnt_mem_q[wr_idx] <= cnt_wr;
      end
   end

   assign bus.data_in_ready_o  = !full;
   assign bus.data_out_valid_o = !empty;
   assign bus.data_out_data_o  = lane_data;
   assign bus.data_out_last_o  = last;

`ifdef VDE_NX1_FIFO_LEVEL_EN
   assign level_o      = wr_ptr_q - rd_ptr_q;
   assign lanes_left_o = empty ? '0 : head_cnt - rd_lane_q;
`endif

   cnt_legal_a: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
      (bus.data_in_valid_i && !full) |->
      (bus.data_in_cnt_i != '0 && bus.data_in_cnt_i <= LW'(LANES)))
      else $warning("vde_nx1_fifo: illegal data_in_cnt_i %0d clamped to LANES",
                    bus.data_in_cnt_i);

endmodule

// File: tb/tb_vde_nx1_fifo.sv
// Directed bench for vde_nx1_fifo: basic drain, full, partial entries, wrap with scoreboard,
// flush and illegal count.
module tb_vde_nx1_fifo;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned LANES = 4;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned LW    = $clog2(LANES + 1);
   localparam int unsigned AW    = $clog2(DEPTH);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   vde_nx1_fifo_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

`ifdef VDE_NX1_FIFO_LEVEL_EN
   logic [AW:0]   level;
   logic [LW-1:0] lanes_left;
`endif

   vde_nx1_fifo #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .bus     (bus.slave)
`ifdef VDE_NX1_FIFO_LEVEL_EN
      ,
      .level_o      (level),
      .lanes_left_o (lanes_left)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_entry(input logic [31:0] d, input logic [LW-1:0] c);
      int n = 0;
      bus.data_in_valid_i = 1'b1;
      bus.data_in_i       = d;
      bus.data_in_cnt_i   = c;
      while (!bus.data_in_ready_o && n < 100) begin
         step();
         n++;
      end
      if (n == 100) check_eq("push_timeout", bus.data_in_ready_o, 1);
      step();
      bus.data_in_valid_i = 1'b0;
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] d, input logic l);
      check_eq({tag, "_valid"}, bus.data_out_valid_o, 1);
      check_eq({tag, "_data"}, bus.data_out_data_o, d);
      check_eq({tag, "_last"}, bus.data_out_last_o, l);
      bus.data_out_ready_i = 1'b1;
      step();
      bus.data_out_ready_i = 1'b0;
   endtask

   initial begin
      logic [8:0]  exp_q[$];
      logic [8:0]  e;
      logic [31:0] cur_d;
      logic [LW-1:0] cur_c;
      bit          have;
      int          sent, cyc;

      bus.data_in_valid_i  = 1'b0;
      bus.data_in_i        = '0;
      bus.data_in_cnt_i    = '0;
      bus.data_out_ready_i = 1'b0;

      // reset
      step();
      step();
      rst = 1'b0;
      check_eq("rst_ready", bus.data_in_ready_o, 1);
      check_eq("rst_valid", bus.data_out_valid_o, 0);
      check_eq("rst_last", bus.data_out_last_o, 0);
`ifdef VDE_NX1_FIFO_LEVEL_EN
      check_eq("rst_level", level, 0);
      check_eq("rst_lanes_left", lanes_left, 0);
`endif

      // 1: full entry, lane order and last flag
      check_eq("t1_ready", bus.data_in_ready_o, 1);
      push_entry(32'h1312_1110, 3'd4);
      pop_expect("t1_l0", 8'h10, 1'b0);
      pop_expect("t1_l1", 8'h11, 1'b0);
      pop_expect("t1_l2", 8'h12, 1'b0);
      pop_expect("t1_l3", 8'h13, 1'b1);
      check_eq("t1_empty", bus.data_out_valid_o, 0);

      // 2: fill to DEPTH, then a final-lane pop frees a slot only on the next cycle
      for (int i = 0; i < 16; i++) begin
         check_eq("t2_ready_fill", bus.data_in_ready_o, 1);
         push_entry({24'hEEEEEE, 8'(8'h20 + i)}, 3'd1);
      end
      check_eq("t2_full", bus.data_in_ready_o, 0);
`ifdef VDE_NX1_FIFO_LEVEL_EN
      check_eq("t2_level", level, 16);
`endif
      bus.data_out_ready_i = 1'b1;
      check_eq("t2_same_cycle_ready", bus.data_in_ready_o, 0);
      check_eq("t2_head_data", bus.data_out_data_o, 8'h20);
      check_eq("t2_head_last", bus.data_out_last_o, 1);
      step();
      bus.data_out_ready_i = 1'b0;
      check_eq("t2_next_cycle_ready", bus.data_in_ready_o, 1);
      for (int i = 1; i < 16; i++) pop_expect("t2_drain", 8'(8'h20 + i), 1'b1);
      check_eq("t2_empty", bus.data_out_valid_o, 0);

      // 3: partial entries
      push_entry(32'hEEEE_EEA0, 3'd1);
      push_entry(32'hB3B2_B1B0, 3'd3);
      pop_expect("t3_a0", 8'hA0, 1'b1);
      pop_expect("t3_b0", 8'hB0, 1'b0);
      pop_expect("t3_b1", 8'hB1, 1'b0);
      pop_expect("t3_b2", 8'hB2, 1'b1);
      check_eq("t3_no_b3", bus.data_out_valid_o, 0);

      // 4: 40 entries, random consumer stalls, scoreboard across pointer wraps
      have = 1'b0;
      sent = 0;
      cyc  = 0;
      while ((sent < 40 || exp_q.size() != 0) && cyc < 3000) begin
         if (!have && sent < 40) begin
            cur_d = $urandom;
            cur_c = LW'($urandom_range(1, 4));
            have  = 1'b1;
         end
         bus.data_in_valid_i  = have;
         bus.data_in_i        = cur_d;
         bus.data_in_cnt_i    = cur_c;
         bus.data_out_ready_i = 1'($urandom_range(0, 1));
         if (bus.data_out_valid_o && bus.data_out_ready_i) begin
            if (exp_q.size() == 0) begin
               check_eq("t4_extra_lane", bus.data_out_valid_o, 0);
            end else begin
               e = exp_q.pop_front();
               check_eq("t4_data", bus.data_out_data_o, e[7:0]);
               check_eq("t4_last", bus.data_out_last_o, e[8]);
            end
         end
         if (have && bus.data_in_ready_o) begin
            for (int k = 0; k < int'(cur_c); k++)
               exp_q.push_back({k == int'(cur_c) - 1, cur_d[k*8 +: 8]});
            have = 1'b0;
            sent++;
         end
         step();
         cyc++;
      end
      bus.data_in_valid_i  = 1'b0;
      bus.data_out_ready_i = 1'b0;
      check_eq("t4_sent", sent, 40);
      check_eq("t4_drained", exp_q.size(), 0);
      check_eq("t4_empty", bus.data_out_valid_o, 0);

      // 5: flush mid-entry with a concurrent push
      push_entry(32'h5352_5150, 3'd4);
      pop_expect("t5_l0", 8'h50, 1'b0);
      pop_expect("t5_l1", 8'h51, 1'b0);
`ifdef VDE_NX1_FIFO_LEVEL_EN
      check_eq("t5_lanes_left", lanes_left, 2);
`endif
      flush = 1'b1;
      bus.data_in_valid_i = 1'b1;
      bus.data_in_i       = 32'h6362_6160;
      bus.data_in_cnt_i   = 3'd4;
      step();
      flush = 1'b0;
      bus.data_in_valid_i = 1'b0;
      check_eq("t5_valid", bus.data_out_valid_o, 0);
      check_eq("t5_ready", bus.data_in_ready_o, 1);
`ifdef VDE_NX1_FIFO_LEVEL_EN
      check_eq("t5_level", level, 0);
      check_eq("t5_lanes_left0", lanes_left, 0);
`endif
      push_entry(32'h7372_7170, 3'd2);
      pop_expect("t5_post0", 8'h70, 1'b0);
      pop_expect("t5_post1", 8'h71, 1'b1);
      check_eq("t5_empty", bus.data_out_valid_o, 0);

      // 6: illegal count 0 drains as a full entry
      push_entry(32'h8382_8180, 3'd0);
      pop_expect("t6_l0", 8'h80, 1'b0);
      pop_expect("t6_l1", 8'h81, 1'b0);
      pop_expect("t6_l2", 8'h82, 1'b0);
      pop_expect("t6_l3", 8'h83, 1'b1);
      check_eq("t6_empty", bus.data_out_valid_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
